// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master port between NREQ requesters.
// Holds the grant for a full request/response round trip, with a response timeout.
module spi_master_arbiter #(
    parameter int NREQ    = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_val,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*DATA_W-1:0] req_msg,
    output logic [NREQ-1:0]        resp_val,
    input  logic [NREQ-1:0]        resp_rdy,
    output logic [DATA_W-1:0]      resp_msg,
    output logic                   resp_err,
    output logic                   mst_req_val,
    input  logic                   mst_req_rdy,
    output logic [DATA_W-1:0]      mst_req_msg,
    input  logic                   mst_resp_val,
    output logic                   mst_resp_rdy,
    input  logic [DATA_W-1:0]      mst_resp_msg,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   resp_drop
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [TW-1:0]     timer;

    logic [PW-1:0]     sel;
    logic              sel_hit;
    logic [DATA_W-1:0] sel_msg;
    logic [PW-1:0]     ptr_nxt;
    logic              to_hit;
    logic              resp_fire;
    int                idx;

    // First requester at or after ptr, wrapping around
    always_comb begin
        sel     = '0;
        sel_hit = 1'b0;
        sel_msg = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!sel_hit && req_val[idx]) begin
                sel_hit = 1'b1;
                sel     = PW'(idx);
                sel_msg = req_msg[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt   = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
    assign to_hit    = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
    assign resp_fire = (state == S_RETURN) && |(resp_rdy & (ONE << owner));

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (sel_hit) state_n = S_SEND;
            S_SEND:   if (mst_req_rdy) state_n = S_WAIT;
            S_WAIT:   if (mst_resp_val || to_hit) state_n = S_RETURN;
            S_RETURN: if (resp_fire) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            owner  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            timer  <= '0;
            grant  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: begin
                    if (sel_hit) begin
                        data_q <= sel_msg;
                        owner  <= sel;
                        grant  <= ONE << sel;
                        ptr    <= ptr_nxt;
                    end
                end
                S_SEND: begin
                    if (mst_req_rdy) timer <= '0;
                end
                S_WAIT: begin
                    // A response on the final timeout cycle still wins
                    if (mst_resp_val) begin
                        data_q <= mst_resp_msg;
                        err_q  <= 1'b0;
                    end else if (to_hit) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RETURN: begin
                    if (resp_fire) grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_rdy      = (state == S_IDLE && sel_hit) ? (ONE << sel) : '0;
    assign mst_req_val  = (state == S_SEND);
    assign mst_req_msg  = data_q;
    assign mst_resp_rdy = (state == S_IDLE) || (state == S_WAIT);
    assign resp_val     = (state == S_RETURN) ? (ONE << owner) : '0;
    assign resp_msg     = data_q;
    assign resp_err     = err_q;
    assign busy         = (state != S_IDLE);
    assign resp_drop    = (state == S_IDLE) && mst_resp_val;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: vector table, corner
// sequences and randomized transactions against a round-robin model.
module tb_spi_master_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_val;
    logic [2:0]  req_rdy;
    logic [95:0] req_msg;
    logic [2:0]  resp_val;
    logic [2:0]  resp_rdy;
    logic [31:0] resp_msg;
    logic        resp_err;
    logic        mst_req_val;
    logic        mst_req_rdy;
    logic [31:0] mst_req_msg;
    logic        mst_resp_val;
    logic        mst_resp_rdy;
    logic [31:0] mst_resp_msg;
    logic [2:0]  grant;
    logic        busy;
    logic        resp_drop;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    spi_master_arbiter #(
        .NREQ(3),
        .DATA_W(32),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .req_msg(req_msg),
        .resp_val(resp_val),
        .resp_rdy(resp_rdy),
        .resp_msg(resp_msg),
        .resp_err(resp_err),
        .mst_req_val(mst_req_val),
        .mst_req_rdy(mst_req_rdy),
        .mst_req_msg(mst_req_msg),
        .mst_resp_val(mst_resp_val),
        .mst_resp_rdy(mst_resp_rdy),
        .mst_resp_msg(mst_resp_msg),
        .grant(grant),
        .busy(busy),
        .resp_drop(resp_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // Model: first requester at or after the rotating pointer
    function automatic int exp_owner(input logic [2:0] rv, input int p);
        for (int k = 0; k < 3; k++)
            if (rv[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    // One full transaction; called and returns at posedge+1
    task automatic do_txn(input logic [2:0] rv, input int own,
                          input int s1, input int s2, input int s3,
                          input logic [31:0] rd);
        logic [2:0]  oh;
        logic [2:0]  nz;
        logic [31:0] em;
        oh = 3'b001 << own;
        nz = 3'($urandom) & ~oh;
        em = req_msg[own*32 +: 32];
        req_val      = rv;
        mst_req_rdy  = (s1 == 0);
        mst_resp_val = 1'b0;
        resp_rdy     = 3'b000;
        @(negedge clk);
        chk("req_rdy_idle", req_rdy, oh);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        for (int c = 0; c < s1; c++) begin
            @(negedge clk);
            chk("send_stall_val", mst_req_val, 1);
            chk("send_stall_msg", mst_req_msg, em);
            chk("send_stall_rdy", req_rdy, 0);
            @(posedge clk); #1;
            if (c == s1 - 1) mst_req_rdy = 1'b1;
        end
        @(negedge clk);
        chk("mst_req_val", mst_req_val, 1);
        chk("mst_req_msg", mst_req_msg, em);
        chk("grant", grant, oh);
        chk("mst_resp_rdy_send", mst_resp_rdy, 0);
        @(posedge clk); #1;
        mst_req_rdy  = 1'b0;
        mst_resp_val = (s2 == 0);
        mst_resp_msg = rd;
        for (int c = 0; c < s2; c++) begin
            @(negedge clk);
            chk("wait_resp_rdy", mst_resp_rdy, 1);
            chk("wait_resp_val", resp_val, 0);
            chk("wait_req_rdy", req_rdy, 0);
            @(posedge clk); #1;
            if (c == s2 - 1) mst_resp_val = 1'b1;
        end
        @(negedge clk);
        chk("wait_resp_rdy", mst_resp_rdy, 1);
        @(posedge clk); #1;
        mst_resp_val = 1'b0;
        resp_rdy     = (s3 == 0) ? oh : nz;
        for (int c = 0; c < s3; c++) begin
            @(negedge clk);
            chk("ret_stall_val", resp_val, oh);
            chk("ret_stall_msg", resp_msg, rd);
            chk("ret_stall_rdy", req_rdy, 0);
            @(posedge clk); #1;
            resp_rdy = (c == s3 - 1) ? (oh | nz) : nz;
        end
        @(negedge clk);
        chk("resp_val", resp_val, oh);
        chk("resp_msg", resp_msg, rd);
        chk("resp_err", resp_err, 0);
        chk("mst_resp_rdy_ret", mst_resp_rdy, 0);
        @(posedge clk); #1;
        resp_rdy = 3'b000;
        chk("grant_after", grant, 0);
        chk("busy_after", busy, 0);
        mptr = (own + 1) % 3;
    endtask

    typedef struct {
        logic [2:0]  rv;
        int          own;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[11];
    int   cnt;

    initial begin
        tbl[0]  = '{3'b111, 0, 32'h0000_1000};
        tbl[1]  = '{3'b111, 1, 32'h0000_1001};
        tbl[2]  = '{3'b111, 2, 32'h0000_1002};
        tbl[3]  = '{3'b111, 0, 32'h0000_1003};
        tbl[4]  = '{3'b111, 1, 32'h0000_1004};
        tbl[5]  = '{3'b111, 2, 32'h0000_1005};
        tbl[6]  = '{3'b010, 1, 32'h1234_5678};
        tbl[7]  = '{3'b101, 2, 32'hDEAD_BEEF};
        tbl[8]  = '{3'b100, 2, 32'h0F0F_0F0F};
        tbl[9]  = '{3'b011, 0, 32'h8000_0001};
        tbl[10] = '{3'b101, 2, 32'hFFFF_FFFF};

        reset        = 1'b0;
        req_val      = 3'b000;
        resp_rdy     = 3'b000;
        mst_req_rdy  = 1'b0;
        mst_resp_val = 1'b0;
        mst_resp_msg = 32'h0;
        for (int i = 0; i < 3; i++)
            req_msg[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_mst_req_val", mst_req_val, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_drop", resp_drop, 0);
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++)
            do_txn(tbl[v].rv, tbl[v].own, 0, 0, 0, tbl[v].rd);

        // Backpressure on both sides, all requesters waiting
        do_txn(3'b111, 0, 5, 0, 4, 32'h5555_AAAA);

        // Timeout: master never answers
        req_val     = 3'b010;
        mst_req_rdy = 1'b1;
        @(negedge clk);
        chk("to_req_rdy", req_rdy, 3'b010);
        @(posedge clk); #1;
        req_val = 3'b000;
        @(posedge clk); #1;
        mst_req_rdy = 1'b0;
        @(negedge clk);
        cnt = 0;
        while (resp_val == 3'b000 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_latency", 64'(cnt), 8);
        chk("to_resp_val", resp_val, 3'b010);
        chk("to_resp_err", resp_err, 1);
        chk("to_resp_msg", resp_msg, 0);
        @(posedge clk); #1;
        resp_rdy = 3'b010;
        @(posedge clk); #1;
        resp_rdy     = 3'b000;
        mst_resp_val = 1'b1;
        mst_resp_msg = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("drop_pulse", resp_drop, 1);
        @(posedge clk); #1;
        mst_resp_val = 1'b0;
        @(negedge clk);
        chk("drop_clear", resp_drop, 0);
        chk("drop_busy", busy, 0);
        @(posedge clk); #1;
        mptr = 2;

        // Response arrives on the last timeout cycle
        req_val     = 3'b100;
        mst_req_rdy = 1'b1;
        @(posedge clk); #1;
        req_val = 3'b000;
        @(posedge clk); #1;
        mst_req_rdy = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        mst_resp_val = 1'b1;
        mst_resp_msg = 32'hCAFE_F00D;
        @(negedge clk);
        chk("sim_wait", resp_val, 0);
        @(posedge clk); #1;
        mst_resp_val = 1'b0;
        @(negedge clk);
        chk("sim_resp_val", resp_val, 3'b100);
        chk("sim_resp_err", resp_err, 0);
        chk("sim_resp_msg", resp_msg, 32'hCAFE_F00D);
        @(posedge clk); #1;
        resp_rdy = 3'b100;
        @(posedge clk); #1;
        resp_rdy = 3'b000;
        mptr = 0;

        // Reset while waiting for a response
        req_val     = 3'b010;
        mst_req_rdy = 1'b1;
        @(posedge clk); #1;
        req_val = 3'b000;
        @(posedge clk); #1;
        mst_req_rdy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rw_busy", busy, 0);
        chk("rw_grant", grant, 0);
        chk("rw_resp_val", resp_val, 0);
        mptr = 0;
        do_txn(3'b110, exp_owner(3'b110, mptr), 0, 0, 0, 32'h0BAD_F00D);

        // Randomized traffic against the rotation model
        for (int t = 0; t < 40; t++) begin
            logic [2:0] rv;
            rv = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++)
                req_msg[i*32 +: 32] = $urandom;
            do_txn(rv, exp_owner(rv, mptr), $urandom_range(0, 3),
                   $urandom_range(0, 5), $urandom_range(0, 3), $urandom);
        end

        req_val = 3'b000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
